// File: rtl/ballot_collector.sv
// Ballot collector: gathers one ballot per voter over valid/ready, rejects repeats and hands
// the packed vote vector to the tally stage. Optional early close with `define BALLOT_CLOSE_EN.
module ballot_collector #(
  parameter int unsigned N = 2,
  parameter int unsigned M = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [M-1:0]         in_voter,
  input  logic [N-1:0]         in_vote,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef BALLOT_CLOSE_EN
  input  logic                 close,
`endif
  output logic [(2**M)*N-1:0]  vote,
  output logic [M:0]           count,
  output logic                 dup_err
);

  localparam int unsigned Voters = 2**M;
  localparam logic [M:0]  Full   = (M+1)'(Voters);

  typedef enum logic {StCollect, StDone} state_e;

  state_e                   state_q, state_d;
  logic [Voters-1:0][N-1:0] slot_q, slot_d;
  logic [Voters-1:0]        received_q, received_d;
  logic [M:0]               count_q, count_d;
  logic                     dup_q, dup_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    received_d = received_q;
    count_d    = count_q;
    dup_d      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      StCollect: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (received_q[in_voter]) begin
            dup_d = 1'b1;
          end else begin
            slot_d[in_voter]     = in_vote;
            received_d[in_voter] = 1'b1;
            count_d              = count_q + (M+1)'(1);
            if (count_d == Full) state_d = StDone;
          end
        end
`ifdef BALLOT_CLOSE_EN
        // Ballot on the same cycle is still recorded above before closing.
        if (close) state_d = StDone;
`endif
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          slot_d     = '0;
          received_d = '0;
          count_d    = '0;
          state_d    = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCollect;
      slot_q     <= '0;
      received_q <= '0;
      count_q    <= '0;
      dup_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      received_q <= received_d;
      count_q    <= count_d;
      dup_q      <= dup_d;
    end
  end

  assign vote    = slot_q;
  assign count   = count_q;
  assign dup_err = dup_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Self-checking bench for ballot_collector: directed test-plan steps plus randomized traffic
// compared against an array-based round model.
module tb_ballot_collector;

  localparam int unsigned N = 2;
  localparam int unsigned M = 2;
  localparam int Voters = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, dup_err, close;
  logic [M-1:0] in_voter;
  logic [N-1:0] in_vote;
  logic [7:0]   vote;
  logic [M:0]   count;

  int checks = 0;
  int failures = 0;

  // Reference round state
  int m_slot [Voters];
  bit m_recv [Voters];
  int m_cnt;
  bit m_done;
  bit m_dup;

  always #5 clk = ~clk;

  ballot_collector #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_voter  (in_voter),
    .in_vote   (in_vote),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BALLOT_CLOSE_EN
    .close     (close),
`endif
    .vote      (vote),
    .count     (count),
    .dup_err   (dup_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_vote();
    logic [7:0] v = '0;
    for (int i = 0; i < Voters; i++) v[i*2 +: 2] = 2'(m_slot[i]);
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, !m_done});
    chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, m_done});
    chk({tag, "_vote"}, {24'd0, vote}, {24'd0, model_vote()});
    chk({tag, "_count"}, {29'd0, count}, 32'(m_cnt));
    chk({tag, "_dup_err"}, {31'd0, dup_err}, {31'd0, m_dup});
  endtask

  task automatic clear_model();
    for (int i = 0; i < Voters; i++) begin
      m_slot[i] = 0;
      m_recv[i] = 1'b0;
    end
    m_cnt  = 0;
    m_done = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    clear_model();
    m_dup = 1'b0;
    #1;
    rst = 1'b0;
    check_all(tag);
  endtask

  // Apply one cycle of inputs, advance the model from the rules, then compare.
  task automatic step(input string tag, input bit v, input int voter, input int vt,
                      input bit ordy, input bit cls);
    in_valid  = v;
    in_voter  = M'(voter);
    in_vote   = N'(vt);
    out_ready = ordy;
    close     = cls;
    @(posedge clk);
    m_dup = 1'b0;
    if (m_done) begin
      if (ordy) clear_model();
    end else begin
      if (v) begin
        if (m_recv[voter]) begin
          m_dup = 1'b1;
        end else begin
          m_slot[voter] = vt;
          m_recv[voter] = 1'b1;
          m_cnt++;
          if (m_cnt == Voters) m_done = 1'b1;
        end
      end
`ifdef BALLOT_CLOSE_EN
      if (cls) m_done = 1'b1;
`endif
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_voter = '0; in_vote = '0; out_ready = 1'b0; close = 1'b0;
    m_dup = 1'b0;
    clear_model();
    @(posedge clk);
    do_reset("rst0");

    // Consecutive voters 0..3 with immediate release
    step("t1a", 1, 0, 1, 1, 0);
    step("t1b", 1, 1, 1, 1, 0);
    step("t1c", 1, 2, 3, 1, 0);
    step("t1d", 1, 3, 2, 1, 0);
    chk("t1_vote_const", {24'd0, vote}, 32'b10_11_01_01);
    chk("t1_count_const", {29'd0, count}, 32'd4);
    chk("t1_ov_const", {31'd0, out_valid}, 32'd1);
    step("t1e", 0, 0, 0, 1, 0);
    chk("t1_ov_drop", {31'd0, out_valid}, 32'd0);
    chk("t1_ir_back", {31'd0, in_ready}, 32'd1);

    // Duplicate voter rejected
    step("t2a", 1, 2, 3, 0, 0);
    step("t2b", 1, 2, 0, 0, 0);
    chk("t2_dup_pulse", {31'd0, dup_err}, 32'd1);
    step("t2c", 0, 0, 0, 0, 0);
    chk("t2_dup_clear", {31'd0, dup_err}, 32'd0);
    chk("t2_slot2", {30'd0, vote[5:4]}, 32'd3);
    chk("t2_count", {29'd0, count}, 32'd1);
    step("t2d", 1, 0, 1, 0, 0);
    step("t2e", 1, 1, 2, 0, 0);
    step("t2f", 1, 3, 0, 0, 0);

    // Held in DONE with out_ready low; ballots ignored
    for (int i = 0; i < 5; i++) step("t3hold", 1, i % Voters, 3, 0, 0);
    chk("t3_vote_held", {24'd0, vote}, 32'b00_11_10_01);
    chk("t3_dup_none", {31'd0, dup_err}, 32'd0);
    step("t3rel", 0, 0, 0, 1, 0);

    // Out-of-order voters
    step("t4a", 1, 3, 0, 1, 0);
    step("t4b", 1, 0, 2, 1, 0);
    step("t4c", 1, 2, 2, 1, 0);
    step("t4d", 1, 1, 1, 1, 0);
    chk("t4_vote_const", {24'd0, vote}, 32'b00_10_01_10);
    chk("t4_ov_const", {31'd0, out_valid}, 32'd1);
    step("t4e", 0, 0, 0, 1, 0);

    // Mid-round reset then a fresh round
    step("t5a", 1, 1, 3, 0, 0);
    step("t5b", 1, 2, 1, 0, 0);
    do_reset("t5rst");
    chk("t5_count0", {29'd0, count}, 32'd0);
    chk("t5_vote0", {24'd0, vote}, 32'd0);
    for (int i = 0; i < Voters; i++) step("t5round", 1, i, 3 - i, 0, 0);
    chk("t5_vote_const", {24'd0, vote}, 32'b00_01_10_11);
    step("t5rel", 0, 0, 0, 1, 0);

`ifdef BALLOT_CLOSE_EN
    step("t6a", 1, 1, 3, 0, 0);
    step("t6b", 1, 0, 2, 0, 1);
    chk("t6_vote_const", {24'd0, vote}, 32'b00_00_11_10);
    chk("t6_count_const", {29'd0, count}, 32'd2);
    chk("t6_ov_const", {31'd0, out_valid}, 32'd1);
    step("t6rel", 0, 0, 0, 1, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", $urandom_range(0, 3) != 0, int'($urandom_range(0, Voters - 1)),
             int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ballot_collector.md
Name: ballot_collector

Overview:
- Sequential front-end for the combinational voting tally.
- Accepts one ballot per cycle from up to 2**M voters over a valid/ready handshake.
- Stores each ballot in the slot indexed by voter ID and rejects repeat ballots.
- Once every voter has voted, presents the packed vote vector (slot i at bits [(i+1)*N-1:i*N]) to the tally stage and holds it until the consumer acknowledges.

Parameters:
- N, 2, candidate ID width (2**N candidates)
- M, 2, voter ID width (2**M voters)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  ballot present
- in_ready  output  1  collector can accept a ballot
- in_voter  input  M  voter ID of the ballot
- in_vote  input  N  candidate ID chosen
- out_valid  output  1  packed vote vector complete and stable
- out_ready  input  1  consumer takes the vector
- vote  output  (2**M)*N  packed ballots; slot i = voter i
- count  output  M+1  number of distinct voters recorded this round
- dup_err  output  1  one-cycle pulse: a ballot from an already-recorded voter was rejected

Behaviour:
- Storage
  - Ballot slots: 2**M registers of N bits.
  - received: 2**M-bit bitmap of recorded voters.
  - count: M+1-bit register.
- State machine: COLLECT, DONE.
- Reset (rst high at a clk edge)
  - State goes to COLLECT; all slots, received, count and dup_err clear to 0.
  - out_valid=0, in_ready=1 (next cycle), vote=0.
  - Reset applied mid-round or while in DONE discards everything; no vector is emitted.
- COLLECT
  - in_ready=1, out_valid=0.
  - A ballot is accepted on a cycle with in_valid && in_ready.
  - If received[in_voter]=0:
    - slot[in_voter] <= in_vote;
    - received[in_voter] <= 1;
    - count <= count+1.
  - If received[in_voter]=1:
    - slot, bitmap and count are unchanged;
    - dup_err=1 in the following cycle only (registered pulse).
  - When an accepted non-duplicate ballot brings count to 2**M, the next state is DONE.
  - count never exceeds 2**M; the M+1 width holds 2**M exactly, so no wrap.
- DONE
  - in_ready=0, out_valid=1.
  - vote and count are held constant.
  - in_valid is ignored: no write and no dup_err.
  - On a cycle with out_valid && out_ready: the next cycle clears slots, bitmap and count to 0 and returns to COLLECT.
  - out_valid deasserts the cycle after the handshake.
  - out_valid is never withdrawn before out_ready.
- Latency
  - Accepted ballot is visible in vote/count the cycle after acceptance.
  - Last ballot accepted at cycle t gives out_valid=1 at t+1.
  - A new round can accept its first ballot at the cycle after the output handshake.
  - Minimum round length: 2**M + 1 cycles.
- vote is always the concatenation of the slot registers. Unvoted slots read 0 (candidate 0). Downstream only samples vote when out_valid=1.
- dup_err is 0 except for its single-cycle pulses.

Optional Feature:
- Macro: BALLOT_CLOSE_EN
- Defined:
  - Adds input port close (1 bit).
  - If close=1 in COLLECT, the next state is DONE regardless of count; missing voters' slots remain 0.
  - If close coincides with an accepted ballot, the ballot is recorded first (including the count increment or dup_err), then DONE.
  - close is ignored in DONE and during rst.
- Undefined:
  - Port close does not exist.
  - DONE is reached only when count reaches 2**M.

Test Plan:
- Reset, then ballots voter0..3 (N=2, M=2) with votes 1,1,3,2 on consecutive cycles, out_ready=1 -> out_valid high for exactly one cycle, vote=8'b10_11_01_01, count=4; in_ready returns to 1 the next cycle.
- Voter 2 votes 3, then voter 2 votes 0 -> second ballot rejected; dup_err is a single-cycle pulse; slot2 stays 3; count=1.
- Full round completes with out_ready=0 for 5 cycles -> out_valid and vote stable throughout; in_ready=0; in_valid ballots in DONE cause no change and no dup_err; release on out_ready=1.
- Out-of-order voters 3,0,2,1 with votes 0,2,2,1 -> vote=8'b00_10_01_10; out_valid the cycle after the fourth ballot.
- rst asserted after 2 ballots -> count=0, vote=0, out_valid=0; a fresh 4-ballot round then completes normally.
- With BALLOT_CLOSE_EN: voter1 votes 3, then close=1 together with voter0 voting 2 -> DONE, vote=8'b00_00_11_10, count=2.
